// File: rtl/axi_lite_regfile_slv.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_slv
//   AXI4-Lite responder holding NumRegs 32-bit control/status registers that
//   are also exposed to hardware in parallel. Address decode has already been
//   done upstream; only the word index bits of the address are used here.
//   One write and one read may be outstanding at a time, independently.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   req_i       AXI-Lite request  (aw, w, b_ready, ar, r_ready)
//   resp_o      AXI-Lite response (aw_ready, w_ready, b, ar_ready, r)
//   reg_q_o     current register contents
//   hw_we_i     per-register hardware load enable (wins over a bus write)
//   hw_d_i      hardware load data
//   wr_pulse_o  one-cycle pulse when a bus write commits to register i
// -----------------------------------------------------------------------------

package ariane_axi_soc;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } aw_chan_lite_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_lite_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_lite_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ar_chan_lite_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_lite_t;

  typedef struct packed {
    aw_chan_lite_t aw;
    logic          aw_valid;
    w_chan_lite_t  w;
    logic          w_valid;
    logic          b_ready;
    ar_chan_lite_t ar;
    logic          ar_valid;
    logic          r_ready;
  } req_lite_t;

  typedef struct packed {
    logic         aw_ready;
    logic         w_ready;
    b_chan_lite_t b;
    logic         b_valid;
    logic         ar_ready;
    r_chan_lite_t r;
    logic         r_valid;
  } resp_lite_t;

endpackage

module axi_lite_regfile_slv
  import ariane_axi_soc::*;
#(
  parameter int unsigned                NumRegs      = 16,
  parameter logic [NumRegs-1:0][31:0]   RegRstVal    = '0,
  parameter logic [NumRegs-1:0]         ReadOnlyMask = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  req_lite_t                     req_i,
  output resp_lite_t                    resp_o,
  output logic [NumRegs-1:0][31:0]      reg_q_o,
  input  logic [NumRegs-1:0]            hw_we_i,
  input  logic [NumRegs-1:0][31:0]      hw_d_i,
  output logic [NumRegs-1:0]            wr_pulse_o
);

  localparam int unsigned      IdxW     = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam logic [IdxW:0]    NumRegsW = (IdxW + 1)'(NumRegs);
  localparam logic [1:0]       RespOkay = 2'b00;
  localparam logic [1:0]       RespSlvErr = 2'b10;

  // write channel capture state
  logic                       r_aw_q;
  logic [IdxW-1:0]            r_aw_idx;
  logic                       r_w_q;
  logic [31:0]                r_w_data;
  logic [3:0]                 r_w_strb;
  logic                       r_b_valid;
  logic [1:0]                 r_b_resp;

  // read channel state
  logic                       r_r_valid;
  logic [31:0]                r_r_data;
  logic [1:0]                 r_r_resp;

  // register array
  logic [NumRegs-1:0][31:0]   r_regs;
  logic [NumRegs-1:0]         r_wr_pulse;

  logic                       w_aw_ready;
  logic                       w_w_ready;
  logic                       w_ar_ready;
  logic                       w_aw_hs;
  logic                       w_w_hs;
  logic                       w_ar_hs;
  logic                       w_commit;
  logic [IdxW-1:0]            w_wr_idx;
  logic [31:0]                w_wr_data;
  logic [3:0]                 w_wr_strb;
  logic                       w_wr_inrange;
  logic [NumRegs-1:0]         w_wr_hit;
  logic [IdxW-1:0]            w_rd_idx;
  logic                       w_rd_inrange;
  logic [31:0]                w_rd_data;
  logic                       w_unused;

  assign w_aw_ready = !r_aw_q && !r_b_valid;
  assign w_w_ready  = !r_w_q && !r_b_valid;
  assign w_ar_ready = !r_r_valid;

  assign w_aw_hs = req_i.aw_valid && w_aw_ready;
  assign w_w_hs  = req_i.w_valid && w_w_ready;
  assign w_ar_hs = req_i.ar_valid && w_ar_ready;

  // The write commits on the edge where the second of AW/W is accepted, so
  // either half may come from the capture registers or straight off the bus.
  assign w_commit  = (r_aw_q || w_aw_hs) && (r_w_q || w_w_hs);
  assign w_wr_idx  = r_aw_q ? r_aw_idx : req_i.aw.addr[IdxW+1:2];
  assign w_wr_data = r_w_q ? r_w_data : req_i.w.data;
  assign w_wr_strb = r_w_q ? r_w_strb : req_i.w.strb;

  assign w_wr_inrange = ({1'b0, w_wr_idx} < NumRegsW);
  assign w_rd_idx     = req_i.ar.addr[IdxW+1:2];
  assign w_rd_inrange = ({1'b0, w_rd_idx} < NumRegsW);

  // Per-register hit vector; read-only and out-of-range targets never hit.
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < NumRegs; i++) begin
      w_wr_hit[i] = w_commit && w_wr_inrange && (w_wr_idx == IdxW'(i)) && !ReadOnlyMask[i];
    end
  end

  // Read mux built as a loop so an out-of-range index simply yields zero.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (w_rd_idx == IdxW'(i)) begin
        w_rd_data = r_regs[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_q    <= 1'b0;
      r_aw_idx  <= '0;
      r_w_q     <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_b_valid <= 1'b0;
      r_b_resp  <= RespOkay;
    end else begin
      if (w_commit) begin
        r_aw_q    <= 1'b0;
        r_w_q     <= 1'b0;
        r_b_valid <= 1'b1;
        r_b_resp  <= w_wr_inrange ? RespOkay : RespSlvErr;
      end else begin
        if (w_aw_hs) begin
          r_aw_q   <= 1'b1;
          r_aw_idx <= req_i.aw.addr[IdxW+1:2];
        end
        if (w_w_hs) begin
          r_w_q    <= 1'b1;
          r_w_data <= req_i.w.data;
          r_w_strb <= req_i.w.strb;
        end
        if (r_b_valid && req_i.b_ready) begin
          r_b_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_r_valid <= 1'b0;
      r_r_data  <= '0;
      r_r_resp  <= RespOkay;
    end else begin
      if (w_ar_hs) begin
        r_r_valid <= 1'b1;
        r_r_data  <= w_rd_inrange ? w_rd_data : 32'h0;
        r_r_resp  <= w_rd_inrange ? RespOkay : RespSlvErr;
      end else if (r_r_valid && req_i.r_ready) begin
        r_r_valid <= 1'b0;
      end
    end
  end

  // Hardware load has priority over a bus write to the same register; the
  // pulse still reports the bus commit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_regs     <= RegRstVal;
      r_wr_pulse <= '0;
    end else begin
      for (int i = 0; i < NumRegs; i++) begin
        if (hw_we_i[i]) begin
          r_regs[i] <= hw_d_i[i];
        end else if (w_wr_hit[i]) begin
          for (int b = 0; b < 4; b++) begin
            if (w_wr_strb[b]) begin
              r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
          end
        end
      end
      r_wr_pulse <= w_wr_hit;
    end
  end

  always_comb begin
    resp_o          = '0;
    resp_o.aw_ready = w_aw_ready;
    resp_o.w_ready  = w_w_ready;
    resp_o.b.resp   = r_b_resp;
    resp_o.b_valid  = r_b_valid;
    resp_o.ar_ready = w_ar_ready;
    resp_o.r.data   = r_r_data;
    resp_o.r.resp   = r_r_resp;
    resp_o.r_valid  = r_r_valid;
  end

  assign reg_q_o    = r_regs;
  assign wr_pulse_o = r_wr_pulse;

  // address bits outside the word index and the prot fields are don't-care
  assign w_unused = ^{req_i.aw.addr[31:IdxW+2], req_i.aw.addr[1:0], req_i.aw.prot,
                      req_i.ar.addr[31:IdxW+2], req_i.ar.addr[1:0], req_i.ar.prot};

  // master-side protocol: payload held while waiting for ready
  a_aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_i.aw_valid && !w_aw_ready |=> req_i.aw_valid && $stable(req_i.aw));
  a_w_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_i.w_valid && !w_w_ready |=> req_i.w_valid && $stable(req_i.w));
  a_ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_i.ar_valid && !w_ar_ready |=> req_i.ar_valid && $stable(req_i.ar));
  // a pending response excludes any further captured write
  a_one_wr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_b_valid |-> !r_aw_q && !r_w_q);

endmodule

// File: tb/tb_axi_lite_regfile_slv.sv
module tb_axi_lite_regfile_slv;
  import ariane_axi_soc::*;

  localparam int NR   = 12;
  localparam int IDXW = $clog2(NR);
  localparam logic [NR-1:0] RO = 12'h088;

  function automatic logic [NR-1:0][31:0] mk_rst();
    logic [NR-1:0][31:0] v;
    for (int i = 0; i < NR; i++) v[i] = 32'h1000_0000 | (i * 32'h11);
    return v;
  endfunction
  localparam logic [NR-1:0][31:0] RST = mk_rst();

  logic                 clk;
  logic                 rst_n;
  req_lite_t            req;
  resp_lite_t           resp;
  logic [NR-1:0][31:0]  reg_q;
  logic [NR-1:0]        hw_we;
  logic [NR-1:0][31:0]  hw_d;
  logic [NR-1:0]        wr_pulse;

  logic [31:0] mdl [NR];
  int n_checks = 0;
  int n_errors = 0;

  axi_lite_regfile_slv #(
    .NumRegs      (NR),
    .RegRstVal    (RST),
    .ReadOnlyMask (RO)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .resp_o     (resp),
    .reg_q_o    (reg_q),
    .hw_we_i    (hw_we),
    .hw_d_i     (hw_d),
    .wr_pulse_o (wr_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, reg_q[i], mdl[i]);
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RST[i];
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & ((1 << IDXW) - 1));
  endfunction

  // reference write: returns response and commit pulse, updates the model
  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] rsp, output logic [NR-1:0] pls);
    int k;
    k = idx_of(a);
    pls = '0;
    if (k >= NR) begin
      rsp = 2'b10;
    end else begin
      rsp = 2'b00;
      if (!RO[k]) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
        pls[k] = 1'b1;
      end
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_hold);
    bit aw_done, w_done, aw_fire, w_fire;
    int c;
    logic [1:0] exp_rsp;
    logic [NR-1:0] exp_pls;
    aw_done = 0; w_done = 0; c = 0;
    req.aw.addr = a;
    req.aw.prot = 3'($urandom);
    req.w.data  = d;
    req.w.strb  = s;
    while (!(aw_done && w_done) && c < 40) begin
      req.aw_valid = !aw_done && (c >= aw_dly);
      req.w_valid  = !w_done && (c >= w_dly);
      @(negedge clk);
      if (aw_done) check("aw_ready_low", resp.aw_ready, 0);
      if (w_done)  check("w_ready_low", resp.w_ready, 0);
      check("b_early", resp.b_valid, 0);
      aw_fire = req.aw_valid && resp.aw_ready;
      w_fire  = req.w_valid && resp.w_ready;
      step();
      aw_done = aw_done || aw_fire;
      w_done  = w_done || w_fire;
      c++;
    end
    req.aw_valid = 0;
    req.w_valid  = 0;
    check("wr_handshake_timeout", {aw_done, w_done}, 2'b11);
    mdl_write(a, d, s, exp_rsp, exp_pls);
    check("b_valid", resp.b_valid, 1);
    check("b_resp", resp.b.resp, exp_rsp);
    check("wr_pulse", wr_pulse, exp_pls);
    check_regs("wr_regs");
    for (int i = 0; i < b_hold; i++) begin
      step();
      check("b_hold", {resp.b_valid, resp.b.resp}, {1'b1, exp_rsp});
      check("w_ready_hold", resp.w_ready, 0);
      check("pulse_one_cycle", wr_pulse, 0);
    end
    req.b_ready = 1;
    step();
    req.b_ready = 0;
    check("b_done", resp.b_valid, 0);
    check("pulse_clr", wr_pulse, 0);
    check("readies_back", {resp.aw_ready, resp.w_ready}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_hold);
    int k;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    k = idx_of(a);
    exp_d = (k < NR) ? mdl[k] : 32'h0;
    exp_r = (k < NR) ? 2'b00 : 2'b10;
    req.ar.addr  = a;
    req.ar.prot  = 3'($urandom);
    req.ar_valid = 1;
    @(negedge clk);
    check("ar_ready", resp.ar_ready, 1);
    step();
    req.ar_valid = 0;
    check("r_valid", resp.r_valid, 1);
    check("r_data", resp.r.data, exp_d);
    check("r_resp", resp.r.resp, exp_r);
    for (int i = 0; i < r_hold; i++) begin
      step();
      check("r_hold", {resp.r_valid, resp.r.resp, resp.r.data}, {1'b1, exp_r, exp_d});
      check("ar_ready_low", resp.ar_ready, 0);
    end
    req.r_ready = 1;
    step();
    req.r_ready = 0;
    check("r_done", resp.r_valid, 0);
  endtask

  task automatic hw_load(input int k, input logic [31:0] d);
    hw_we[k] = 1'b1;
    hw_d[k]  = d;
    step();
    hw_we = '0;
    mdl[k] = d;
    check_regs("hw_regs");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old0, rd;
    int op;
    req   = '0;
    hw_we = '0;
    hw_d  = '0;
    rst_n = 1'b0;
    mdl_reset();
    repeat (3) step();
    check("rst_readies", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b111);
    check("rst_valids", {resp.b_valid, resp.r_valid}, 2'b00);
    check("rst_resps", {resp.b.resp, resp.r.resp}, 4'h0);
    check("rst_rdata", resp.r.data, 0);
    check("rst_pulse", wr_pulse, 0);
    check_regs("rst_regs");
    rst_n = 1'b1;
    step();
    check("post_rst_readies", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b111);

    // 1: same-cycle AW/W
    do_write(32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    // 2: W three cycles ahead of AW, low byte only
    do_write(32'h4, 32'h0000_00AA, 4'h1, 3, 0, 1);
    check("partial_strb", reg_q[1], 32'h1000_00AA);
    // 3: out-of-range read held for 5 cycles
    do_read(32'h4 * NR, 5);
    // 4: read-only register, then hardware load
    do_write(32'hC, 32'h1234, 4'hF, 0, 0, 0);
    check("ro_unchanged", reg_q[3], RST[3]);
    hw_load(3, 32'h55);
    do_read(32'hC, 0);
    // strb = 0 still pulses, nothing changes
    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 1, 0, 0);
    // out-of-range write
    do_write(32'h3C, 32'h5A5A_5A5A, 4'hF, 0, 2, 1);

    // 5: bus commit, hw load and read all on the same edge to reg 0
    old0 = mdl[0];
    req.aw.addr  = 32'h0;
    req.w.data   = 32'hCAFE_F00D;
    req.w.strb   = 4'hF;
    req.ar.addr  = 32'h0;
    req.aw_valid = 1; req.w_valid = 1; req.ar_valid = 1;
    hw_we[0] = 1'b1; hw_d[0] = 32'h77;
    @(negedge clk);
    check("c5_readies", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b111);
    step();
    req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0;
    hw_we = '0;
    mdl[0] = 32'h77;
    check("c5_b", {resp.b_valid, resp.b.resp}, {1'b1, 2'b00});
    check("c5_pulse", wr_pulse, 1);
    check("c5_hw_wins", reg_q[0], 32'h77);
    check("c5_r_old", {resp.r_valid, resp.r.data}, {1'b1, old0});
    req.b_ready = 1; req.r_ready = 1;
    step();
    req.b_ready = 0; req.r_ready = 0;
    check("c5_done", {resp.b_valid, resp.r_valid}, 2'b00);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0)
        do_write({26'($urandom), 6'($urandom) & 6'h3C} | 32'($urandom_range(0, 3)), $urandom,
                 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)));
      else if (op == 1)
        do_read($urandom, int'($urandom_range(0, 2)));
      else
        hw_load(int'($urandom_range(0, NR - 1)), $urandom);
    end

    // 6: reset with both responses pending
    req.aw.addr = 32'h14; req.w.data = 32'h0BAD_0BAD; req.w.strb = 4'hF;
    req.ar.addr = 32'h18;
    req.aw_valid = 1; req.w_valid = 1; req.ar_valid = 1;
    step();
    req.aw_valid = 0; req.w_valid = 0; req.ar_valid = 0;
    check("c6_pending", {resp.b_valid, resp.r_valid, wr_pulse[5]}, 3'b111);
    #2;
    rst_n = 1'b0;
    #1;
    mdl_reset();
    check("c6_valids_drop", {resp.b_valid, resp.r_valid}, 2'b00);
    check("c6_pulse", wr_pulse, 0);
    check_regs("c6_regs");
    step();
    rst_n = 1'b1;
    step();
    check("c6_readies", {resp.aw_ready, resp.w_ready, resp.ar_ready}, 3'b111);
    do_read(32'h14, 0);
    rd = mdl[2];
    do_write(32'h8, ~rd, 4'hF, 0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
